fp_align_unpack: RTL and testbench
==================================

Name: fp_align_unpack

Overview:
- Front end of the single-precision FP adder datapath. Accepts two IEEE-754 binary32 operands and unpacks them into sign, exponent and extended mantissa fields.
- Orders the operands by magnitude, then right-aligns the smaller mantissa one bit per cycle with sticky collection.
- Emits both mantissas in the 29-bit extended format that the adder and normalizer consume:
  - bit 28: carry/overflow, cleared here
  - bit 27: hidden bit
  - bits 26:4: fraction
  - bits 3:0: guard/round/sticky

Parameters:
MAX_SHIFT, 28, cap on alignment shift count; at 28 or more shifts every source bit has reached the sticky position.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair
op_a  input  32  IEEE binary32 operand A
op_b  input  32  IEEE binary32 operand B
out_valid  output  1  aligned result valid
out_ready  input  1  consumer accepts result
mant_big  output  29  mantissa of larger-magnitude operand, unshifted
mant_small  output  29  mantissa of smaller-magnitude operand, aligned to exp_out
exp_out  output  8  effective exponent of larger operand
sign_big  output  1  sign of larger operand
sign_small  output  1  sign of smaller operand
swapped  output  1  1 if op_b is the larger operand
is_nan  output  1  either operand NaN
is_inf  output  1  either operand infinity (and neither NaN)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE. All registered outputs 0: mant_big, mant_small, exp_out, signs, swapped, is_nan, is_inf, out_valid. in_ready is 0 while rst is high.
- Reset mid-operation: any in-flight pair is discarded. In the cycle after the reset edge, out_valid=0 and state is IDLE.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1, all outputs held stable.
- Accept: in_valid and in_ready high at clock edge E0. The block registers the unpacked fields at E0.
- Unpack, per operand:
  - exp field 0 (zero or denormal): hidden bit 0, effective exponent 1.
  - otherwise: hidden bit 1, effective exponent = exp field.
  - mantissa = {1'b0, hidden, frac[22:0], 4'b0000}.
- Ordering:
  - Larger effective exponent is "big".
  - Equal exponents: larger fraction is big.
  - Full tie: op_a is big (swapped=0).
- Shift count: d = min(exp_big_eff - exp_small_eff, MAX_SHIFT).
  - If is_nan or is_inf, d is forced to 0 and the mantissas pass through unshifted.
- Transition out of IDLE at E0: d=0 goes to DONE; d>0 goes to SHIFT with count=d.
- SHIFT, each edge:
  - mant_small = {1'b0, mant_small[28:2], mant_small[1] | mant_small[0]}, so bit 0 is sticky: the OR of every bit shifted past it.
  - count decrements; when it reaches 0 the state goes to DONE on that same edge.
- Latency: out_valid is visible in the cycle following edge E0+d, i.e. one cycle per shift. No extra pipeline bubble.
- DONE:
  - Holds outputs until out_valid and out_ready are both high at an edge, then goes to IDLE.
  - No same-cycle re-accept: in_ready rises the cycle after the handshake.
- exp_out = effective exponent of big operand. A denormal big operand yields exp_out=1.
- Zero operands are ordinary: mantissa 0, effective exponent 1. No flag is raised.
- is_inf does not resolve inf-inf; the adder decides using the signs.
- mant_big and bit 28 of both mantissas are never modified by this block.

Test Plan:
1. Shift by one: op_a=0x3F800000 (1.0), op_b=0x40000000 (2.0) -> d=1. out_valid in the cycle after E0+1; mant_big=0x8000000, mant_small=0x4000000, exp_out=0x80, swapped=1.
2. Equal exponents: op_a=op_b=0x3FC00000 -> d=0. out_valid in the cycle after E0; both mantissas 0xC000000, exp_out=0x7F, swapped=0.
3. Sticky collection: op_a=0x4B800000, op_b=0x3F800001 -> d=24. mant_small=0x0000009 (bit 3 set, sticky=1); out_valid after 24 shift edges.
4. Shift cap: op_a=0x7F000000, op_b=0x3F800000 -> raw diff 127, capped to 28. mant_small=0x0000001, exp_out=0xFE; out_valid after 28 edges.
5. Specials and denormal:
   - op_a=0x7FC00000, op_b=0x3F800000 -> is_nan=1, d=0, out_valid in the cycle after E0.
   - op_a=0x7F800000, op_b=0xFF800000 -> is_inf=1, is_nan=0.
   - op_a=0x00800000, op_b=0x00000001 -> d=0, mant_small=0x0000010, exp_out=1.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
   - Pulse rst during SHIFT of a d=20 pair -> next cycle out_valid=0 and all outputs 0; in_ready=1 once rst is low. A new pair then completes normally.

Source files
------------

// File: rtl/fp_align_unpack.sv
// Front end of the binary32 adder: unpacks two operands and orders them by magnitude.
// It then right-aligns the smaller mantissa one bit per cycle, folding lost bits into a sticky bit.
module fp_align_unpack #(
    parameter int MAX_SHIFT = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [28:0] mant_big,
    output logic [28:0] mant_small,
    output logic [7:0]  exp_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swapped,
    output logic        is_nan,
    output logic        is_inf
);
    localparam int CW = $clog2(MAX_SHIFT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;

    logic [7:0]    exp_a, exp_b, eff_a, eff_b, diff;
    logic [28:0]   man_a, man_b;
    logic          nan_a, nan_b, inf_a, inf_b;
    logic          b_big, any_nan, any_inf;
    logic [CW-1:0] shift_d;

    always_comb begin
        exp_a   = op_a[30:23];
        exp_b   = op_b[30:23];
        eff_a   = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eff_b   = (exp_b == 8'd0) ? 8'd1 : exp_b;
        man_a   = {1'b0, |exp_a, op_a[22:0], 4'b0000};
        man_b   = {1'b0, |exp_b, op_b[22:0], 4'b0000};
        nan_a   = (&exp_a) & (|op_a[22:0]);
        nan_b   = (&exp_b) & (|op_b[22:0]);
        inf_a   = (&exp_a) & ~(|op_a[22:0]);
        inf_b   = (&exp_b) & ~(|op_b[22:0]);
        any_nan = nan_a | nan_b;
        any_inf = (inf_a | inf_b) & ~any_nan;
        // Exponent ties are broken on the whole mantissa, hidden bit included; a full tie keeps op_a big.
        b_big   = {eff_b, man_b} > {eff_a, man_a};
        diff    = b_big ? (eff_b - eff_a) : (eff_a - eff_b);
        if (any_nan || inf_a || inf_b)
            shift_d = '0;
        else if (diff >= 8'(MAX_SHIFT))
            shift_d = CW'(MAX_SHIFT);
        else
            shift_d = diff[CW-1:0];
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);

    // NOTE: the datapath registers are cleared on reset too, so a discarded pair leaves nothing on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            exp_out    <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mant_big   <= b_big ? man_b : man_a;
                        mant_small <= b_big ? man_a : man_b;
                        exp_out    <= b_big ? eff_b : eff_a;
                        sign_big   <= b_big ? op_b[31] : op_a[31];
                        sign_small <= b_big ? op_a[31] : op_b[31];
                        swapped    <= b_big;
                        is_nan     <= any_nan;
                        is_inf     <= any_inf;
                        count      <= shift_d;
                        state      <= (shift_d == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    mant_small <= {1'b0, mant_small[28:2], mant_small[1] | mant_small[0]};
                    count      <= count - 1'b1;
                    if (count == CW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_unpack.sv
// Scoreboard bench for fp_align_unpack: a driver pushes model results, a monitor pops and compares.
// The model orders operands by value and aligns with plain integer division.
module tb_fp_align_unpack;
    localparam int MAX_SHIFT = 28;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op_a, op_b;
    logic [28:0] mant_big, mant_small;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small, swapped, is_nan, is_inf;

    fp_align_unpack #(.MAX_SHIFT(MAX_SHIFT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .mant_big(mant_big), .mant_small(mant_small), .exp_out(exp_out),
        .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped),
        .is_nan(is_nan), .is_inf(is_inf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] mant_big;
        logic [28:0] mant_small;
        logic [7:0]  exp_out;
        logic        sign_big;
        logic        sign_small;
        logic        swapped;
        logic        is_nan;
        logic        is_inf;
        int          d;
        longint      due;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     force_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, "_mant_big"}, 64'(mant_big), 64'(e.mant_big));
        check({tag, "_mant_small"}, 64'(mant_small), 64'(e.mant_small));
        check({tag, "_exp_out"}, 64'(exp_out), 64'(e.exp_out));
        check({tag, "_sign_big"}, 64'(sign_big), 64'(e.sign_big));
        check({tag, "_sign_small"}, 64'(sign_small), 64'(e.sign_small));
        check({tag, "_swapped"}, 64'(swapped), 64'(e.swapped));
        check({tag, "_is_nan"}, 64'(is_nan), 64'(e.is_nan));
        check({tag, "_is_inf"}, 64'(is_inf), 64'(e.is_inf));
    endtask

    // Mantissa values are integers scaled by 16 so the four low guard positions exist.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint ea, eb, ma, mb, small_m, pow, kept;
        bit     nan_a, nan_b, inf_a, inf_b, b_wins;
        int     diff;
        ea    = (a[30:23] == 0) ? 1 : longint'(a[30:23]);
        eb    = (b[30:23] == 0) ? 1 : longint'(b[30:23]);
        ma    = (((a[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0])) * 16;
        mb    = (((b[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0])) * 16;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        b_wins = (eb > ea) || ((eb == ea) && (mb > ma));
        e.swapped    = b_wins;
        e.is_nan     = nan_a || nan_b;
        e.is_inf     = (inf_a || inf_b) && !e.is_nan;
        e.exp_out    = 8'(b_wins ? eb : ea);
        e.sign_big   = b_wins ? b[31] : a[31];
        e.sign_small = b_wins ? a[31] : b[31];
        e.mant_big   = 29'(b_wins ? mb : ma);
        small_m      = b_wins ? ma : mb;
        diff         = int'(b_wins ? eb - ea : ea - eb);
        e.d          = (nan_a || nan_b || inf_a || inf_b) ? 0 : ((diff > MAX_SHIFT) ? MAX_SHIFT : diff);
        pow          = longint'(1) << e.d;
        kept         = small_m / pow;
        // The lowest surviving position becomes sticky for everything at or below it.
        e.mant_small = 29'((kept / 2) * 2 + (((small_m % (pow * 2)) != 0) ? 1 : 0));
        e.due        = 0;
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        e        = model(a, b);
        e.due    = cyc + e.d;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per result, then checks the held outputs until the handshake.
    initial begin
        exp_t cur;
        bit   busy = 1'b0;
        int   held = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                held = 0;
            end else if (out_valid) begin
                if (!busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        cur  = sb_q.pop_front();
                        busy = 1'b1;
                        held = 0;
                        check("latency", 64'(cyc), 64'(cur.due));
                        check_fields("result", cur);
                    end
                end else begin
                    check_fields("hold", cur);
                end
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                held++;
                out_ready = (force_stall && held <= 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end else begin
                busy      = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        int          waited;
        rst      = 1'b1;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mant_big", 64'(mant_big), 64'd0);
        check("rst_mant_small", 64'(mant_small), 64'd0);
        check("rst_flags", 64'({exp_out, sign_big, sign_small, swapped, is_nan, is_inf}), 64'd0);
        rst = 1'b0;

        issue(32'h3F80_0000, 32'h4000_0000);
        issue(32'h3FC0_0000, 32'h3FC0_0000);
        issue(32'h4B80_0000, 32'h3F80_0001);
        issue(32'h7F00_0000, 32'h3F80_0000);
        issue(32'h7FC0_0000, 32'h3F80_0000);
        issue(32'h7F80_0000, 32'hFF80_0000);
        issue(32'h0080_0000, 32'h0000_0001);
        issue(32'h8000_0000, 32'h0000_0000);

        force_stall = 1'b1;
        issue(32'hC120_0000, 32'h4140_0000);
        issue(32'h3F80_0000, 32'hBF00_0000);
        force_stall = 1'b0;

        // Reset in the middle of a 20-step alignment; that pair must never appear.
        issue(32'h4980_0000, 32'h3F80_0000);
        void'(sb_q.pop_back());
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_mant_big", 64'(mant_big), 64'd0);
        check("midrst_mant_small", 64'(mant_small), 64'd0);
        check("midrst_flags", 64'({exp_out, sign_big, sign_small, swapped, is_nan, is_inf}), 64'd0);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        issue(32'h4980_0000, 32'h3F80_0000);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                0: b[30:23] = a[30:23] - 8'($urandom_range(0, 6));
                1: b[30:23] = 8'd0;
                2: b = {~a[31], a[30:0]};
                default: ;
            endcase
            if (i % 5 == 0) a[30:23] = 8'($urandom_range(250, 255));
            issue(a, b);
        end

        waited = 0;
        while ((sb_q.size() != 0 || out_valid) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
